// File: rtl/pipe_ifid_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ifid_queue_pkg
// Description : Shared pipeline definitions: datapath widths, the NOP
//               encoding and the {pc4, inst} record carried from IF to ID.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ifid_queue_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    // sll $0,$0,0 - the canonical MIPS bubble
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc4;
        logic [INST_W-1:0] inst;
    } ifid_entry_t;

    // Entry that represents "nothing here": zero PC+4 and the given NOP word
    function automatic ifid_entry_t ifid_bubble(input logic [INST_W-1:0] nop);
        ifid_entry_t e;
        e.pc4  = '0;
        e.inst = nop;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ifid_queue_entry_ram.sv
`default_nettype none
// ============================================================================
// Module      : ifid_entry_ram
// Description : DEPTH x {pc4, inst} register array, one synchronous write
//               port and one combinational read port. Reset clears every
//               entry to the bubble value.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_entry_ram
    import pipe_ifid_queue_pkg::*;
#(
    parameter int                DEPTH = 2,
    parameter logic [INST_W-1:0] NOP   = NOP_INST,
    localparam int               AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  ifid_entry_t       wr_data,
    input  logic [AW-1:0]     rd_addr,
    output ifid_entry_t       rd_data
);

    ifid_entry_t mem [DEPTH];

    // Storage write; asynchronous reset so no stale entry survives reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= ifid_bubble(NOP);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/pipe_ifid_queue.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ifid_queue
// Description : Small in-order instruction queue between IF and ID. Fetch
//               pushes {pc4, inst} under valid/ready, decode pops under
//               valid/ready, and flush empties the queue on a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ifid_queue
    import pipe_ifid_queue_pkg::*;
#(
    parameter int                DEPTH = 2,
    parameter logic [INST_W-1:0] NOP   = NOP_INST,
    localparam int               AW    = $clog2(DEPTH),
    localparam int               CW    = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc4,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CW-1:0]     count
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    ifid_entry_t   wr_entry;
    ifid_entry_t   head_entry;

    // Full queue never accepts, even when a pop frees a slot in the same cycle
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);

    // Flush overrides both sides of the handshake
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign wr_entry.pc4  = in_pc4;
    assign wr_entry.inst = in_inst;

    ifid_entry_ram #(
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) u_ram (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    // Head presented to decode; an empty queue shows a bubble
    always_comb begin
        out_pc4  = '0;
        out_inst = NOP;
        if (out_valid) begin
            out_pc4  = head_entry.pc4;
            out_inst = head_entry.inst;
        end
    end

    // Pointer and occupancy bookkeeping; flush realigns read to write
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
        push |-> (count != CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clock) disable iff (!resetn)
        pop |-> (count != '0));
    a_count_range: assert property (@(posedge clock) disable iff (!resetn)
        count <= CW'(DEPTH));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ifid_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ifid_queue
// Description : Self-checking bench for pipe_ifid_queue: directed vector
//               table, queue-model random traffic and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ifid_queue;
    import pipe_ifid_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          resetn;
    logic          in_valid;
    logic [31:0]   in_pc4;
    logic [31:0]   in_inst;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic [31:0]   out_pc4;
    logic [31:0]   out_inst;
    logic          out_ready;
    logic [CW-1:0] count;

    int checks;
    int errors;

    ifid_entry_t q[$];

    pipe_ifid_queue #(
        .DEPTH (DEPTH),
        .NOP   (32'h0000_0000)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_pc4    (in_pc4),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc4   (out_pc4),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e_inst;
        int          e_count;
        logic        e_ready;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic fl, input logic rdy);
        in_valid  = v;
        in_pc4    = pc;
        in_inst   = inst;
        flush     = fl;
        out_ready = rdy;
    endtask

    // Compare current outputs against the queue model contents
    task automatic check_model(input string tag);
        logic [31:0] e_pc;
        logic [31:0] e_in;
        e_pc = 32'h0;
        e_in = NOP_INST;
        if (q.size() != 0) begin
            e_pc = q[0].pc4;
            e_in = q[0].inst;
        end
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        check({tag, ".out_pc4"},   out_pc4,        e_pc);
        check({tag, ".out_inst"},  out_inst,       e_in);
    endtask

    // One cycle: drive at negedge, check before the edge, update model at the edge
    task automatic model_cycle(input string tag, input logic v, input logic [31:0] pc,
                               input logic [31:0] inst, input logic fl, input logic rdy);
        bit do_push;
        bit do_pop;
        ifid_entry_t e;
        drive(v, pc, inst, fl, rdy);
        #1;
        check_model(tag);
        do_push = v && (q.size() < DEPTH) && !fl;
        do_pop  = (q.size() != 0) && rdy && !fl;
        @(posedge clock);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc4  = pc;
                e.inst = inst;
                q.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset held with random inputs: nothing may enter the queue
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
            #1;
            check("rst.count",     32'(count),     32'd0);
            check("rst.out_valid", 32'(out_valid), 32'd0);
            check("rst.out_inst",  out_inst,       32'h0);
            check("rst.out_pc4",   out_pc4,        32'h0);
            check("rst.in_ready",  32'(in_ready),  32'd1);
        end
        @(negedge clock);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        resetn = 1'b1;

        // Directed vectors: inputs for the cycle and outputs seen before its edge
        vt[0]  = '{1'b1, 32'h04, 32'h2008_0001, 1'b0, 1'b1, 1'b0, 32'h00, 32'h0000_0000, 0, 1'b1};
        vt[1]  = '{1'b1, 32'h08, 32'h2009_0002, 1'b0, 1'b1, 1'b1, 32'h04, 32'h2008_0001, 1, 1'b1};
        vt[2]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h08, 32'h2009_0002, 1, 1'b1};
        vt[3]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h00, 32'h0000_0000, 0, 1'b1};
        vt[4]  = '{1'b1, 32'h04, 32'h2008_0001, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0000_0000, 0, 1'b1};
        vt[5]  = '{1'b1, 32'h08, 32'h2009_0002, 1'b0, 1'b0, 1'b1, 32'h04, 32'h2008_0001, 1, 1'b1};
        vt[6]  = '{1'b1, 32'h0C, 32'h200A_0003, 1'b0, 1'b0, 1'b1, 32'h04, 32'h2008_0001, 2, 1'b0};
        vt[7]  = '{1'b1, 32'h0C, 32'h200A_0003, 1'b0, 1'b1, 1'b1, 32'h04, 32'h2008_0001, 2, 1'b0};
        vt[8]  = '{1'b1, 32'h0C, 32'h200A_0003, 1'b0, 1'b1, 1'b1, 32'h08, 32'h2009_0002, 1, 1'b1};
        vt[9]  = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h200A_0003, 1, 1'b1};
        vt[10] = '{1'b1, 32'h10, 32'h200B_0004, 1'b0, 1'b0, 1'b1, 32'h0C, 32'h200A_0003, 1, 1'b1};
        vt[11] = '{1'b1, 32'h14, 32'h200C_0005, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h200A_0003, 2, 1'b0};
        vt[12] = '{1'b1, 32'h18, 32'h200D_0006, 1'b0, 1'b1, 1'b0, 32'h00, 32'h0000_0000, 0, 1'b1};
        vt[13] = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h18, 32'h200D_0006, 1, 1'b1};
        vt[14] = '{1'b0, 32'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0000_0000, 0, 1'b1};

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].v, vt[i].pc4, vt[i].inst, vt[i].fl, vt[i].rdy);
            #1;
            check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            check($sformatf("vec%0d.out_pc4", i),   out_pc4,        vt[i].e_pc4);
            check($sformatf("vec%0d.out_inst", i),  out_inst,       vt[i].e_inst);
            check($sformatf("vec%0d.count", i),     32'(count),     32'(vt[i].e_count));
            check($sformatf("vec%0d.in_ready", i),  32'(in_ready),  32'(vt[i].e_ready));
            @(posedge clock);
            @(negedge clock);
        end

        // Continuous streaming across several pointer wraps
        q.delete();
        for (int i = 0; i < 10; i++) begin
            model_cycle("wrap", 1'b1, 32'(4 * (i + 1)), 32'h3000_0000 + 32'(i), 1'b0, 1'b1);
        end

        // Random traffic with stalls and occasional flushes
        for (int i = 0; i < 300; i++) begin
            model_cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                        1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        // Fill the queue, then drop reset between edges
        model_cycle("pre_arst", 1'b1, 32'h40, 32'h2400_0001, 1'b0, 1'b0);
        model_cycle("pre_arst", 1'b1, 32'h44, 32'h2400_0002, 1'b0, 1'b0);
        check("pre_arst.full", 32'(count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("arst.count",     32'(count),     32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd1);
        check("arst.out_pc4",   out_pc4,        32'h0);
        check("arst.out_inst",  out_inst,       32'h0);
        q.delete();
        @(negedge clock);
        resetn = 1'b1;

        // After release nothing from before reset may reappear
        model_cycle("post_arst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            model_cycle("post_arst", 1'($urandom_range(0, 1)), $urandom, $urandom,
                        1'b0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
